// File: rtl/qr_pkg.sv
// rtl/qr_pkg.sv - shared defaults and FSM state encoding for the QR output packer
package qr_pkg;

  localparam int TBITS_DEF   = 64;
  localparam int TBYTE_DEF   = TBITS_DEF / 8;
  localparam int NUM_COL_DEF = 8;

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } qr_state_e;

endpackage

// File: rtl/qr_out_packer.sv
// rtl/qr_out_packer.sv - collects one frame of CORDIC result words, then drains it as a stream
// Optional QR_OUT_TLAST_EN: drive TLAST on the final beat of each frame (otherwise tied to 0).
module qr_out_packer
  import qr_pkg::*;
#(
  parameter int TBITS   = TBITS_DEF,
  parameter int TBYTE   = TBYTE_DEF,
  parameter int NUM_COL = NUM_COL_DEF
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             res_valid,
  output logic             res_ready,
  input  logic [TBITS-1:0] res_data,
  output logic             M_AXIS_S2MM_TVALID,
  input  logic             M_AXIS_S2MM_TREADY,
  output logic [TBITS-1:0] M_AXIS_S2MM_TDATA,
  output logic [TBYTE-1:0] M_AXIS_S2MM_TKEEP,
  output logic             M_AXIS_S2MM_TLAST,
  output logic             frame_done,
  output logic             ovf_err
);

  localparam int PW = $clog2(NUM_COL);
  localparam logic [PW-1:0] LAST_IDX = PW'(NUM_COL - 1);

  qr_state_e        state_q, state_d;
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [TBITS-1:0] buf_mem [NUM_COL];

  logic accept, beat, wr_last, rd_last;

  assign wr_last = (wr_ptr == LAST_IDX);
  assign rd_last = (rd_ptr == LAST_IDX);
  assign accept  = res_valid && (state_q == FILL);
  assign beat    = (state_q == DRAIN) && M_AXIS_S2MM_TREADY;

  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL:    if (accept && wr_last) state_d = DRAIN;
      DRAIN:   if (beat && rd_last)   state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  // Control state is reset; the buffer itself is not, a discarded frame is simply overwritten.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= FILL;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      frame_done <= 1'b0;
      ovf_err    <= 1'b0;
    end else begin
      state_q    <= state_d;
      frame_done <= beat && rd_last;
      if (accept)
        wr_ptr <= wr_ptr + PW'(1);
      if (beat)
        rd_ptr <= rd_ptr + PW'(1);
      if (res_valid && !res_ready)
        ovf_err <= 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    if (accept)
      buf_mem[wr_ptr] <= res_data;
  end

  assign res_ready          = (state_q == FILL);
  assign M_AXIS_S2MM_TVALID = (state_q == DRAIN);
  assign M_AXIS_S2MM_TDATA  = buf_mem[rd_ptr];
  assign M_AXIS_S2MM_TKEEP  = {TBYTE{M_AXIS_S2MM_TVALID}};

`ifdef QR_OUT_TLAST_EN
  assign M_AXIS_S2MM_TLAST = M_AXIS_S2MM_TVALID && rd_last;
`else
  assign M_AXIS_S2MM_TLAST = 1'b0;
`endif

endmodule

// File: tb/tb_qr_out_packer.sv
// tb/tb_qr_out_packer.sv - scoreboard bench for qr_out_packer
module tb_qr_out_packer;

  localparam int TBITS   = 64;
  localparam int TBYTE   = 8;
  localparam int NUM_COL = 8;

  logic             aclk;
  logic             aresetn;
  logic             res_valid;
  logic             res_ready;
  logic [TBITS-1:0] res_data;
  logic             tvalid;
  logic             tready;
  logic [TBITS-1:0] tdata;
  logic [TBYTE-1:0] tkeep;
  logic             tlast;
  logic             frame_done;
  logic             ovf_err;

  qr_out_packer #(.TBITS(TBITS), .TBYTE(TBYTE), .NUM_COL(NUM_COL)) dut (
    .aclk               (aclk),
    .aresetn            (aresetn),
    .res_valid          (res_valid),
    .res_ready          (res_ready),
    .res_data           (res_data),
    .M_AXIS_S2MM_TVALID (tvalid),
    .M_AXIS_S2MM_TREADY (tready),
    .M_AXIS_S2MM_TDATA  (tdata),
    .M_AXIS_S2MM_TKEEP  (tkeep),
    .M_AXIS_S2MM_TLAST  (tlast),
    .frame_done         (frame_done),
    .ovf_err            (ovf_err)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  typedef struct {
    logic [TBITS-1:0] d;
    bit               last;
  } exp_t;

  exp_t             exp_q[$];
  logic [TBITS-1:0] cur[$];
  int               errors = 0;
  int               checks = 0;
  int               exp_frames = 0;
  int               fd_cnt = 0;
  bit               exp_ovf = 0;
  bit               expect_valid = 0;
  int               tr_mode = 0;

  task automatic chk(input bit ok, input string name, input logic [TBITS-1:0] act,
                     input logic [TBITS-1:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: a frame becomes visible for draining only once NUM_COL words are accepted.
  task automatic model_accept(input logic [TBITS-1:0] d);
    chk(exp_q.size() == 0, "accept_during_drain", TBITS'(exp_q.size()), '0);
    cur.push_back(d);
    if (cur.size() == NUM_COL) begin
      for (int i = 0; i < NUM_COL; i++) begin
        exp_t e;
        e.d    = cur[i];
        e.last = (i == NUM_COL - 1);
        exp_q.push_back(e);
      end
      cur.delete();
      exp_frames++;
      expect_valid = 1;
    end
  endtask

  task automatic send_word(input logic [TBITS-1:0] d);
    int n;
    if (exp_q.size() != 0) exp_ovf = 1;
    res_valid = 1'b1;
    res_data  = d;
    n = 0;
    @(negedge aclk);
    while (!res_ready && n < 500) begin
      @(negedge aclk);
      n++;
    end
    chk(n < 500, "accept_timeout", TBITS'(n), '0);
    @(posedge aclk);
    #1;
    res_valid = 1'b0;
    model_accept(d);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge aclk);
      #1;
    end
  endtask

  task automatic wait_drained();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge aclk);
      n++;
    end
    chk(exp_q.size() == 0, "drain_timeout", TBITS'(exp_q.size()), '0);
    idle(2);
  endtask

  // Downstream ready generator.
  initial begin
    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int ph = 0;
    tready = 1'b0;
    forever begin
      @(posedge aclk);
      #1;
      case (tr_mode)
        0:       tready = 1'b1;
        1:       begin tready = pat[ph]; ph = (ph + 1) % 4; end
        2:       tready = 1'($urandom_range(0, 1));
        default: tready = 1'b0;
      endcase
    end
  end

  // Monitor: compares every presented beat against the head of the scoreboard.
  initial begin
    bit   prev_last = 0;
    exp_t e;
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        prev_last    = 0;
        expect_valid = 0;
      end else begin
        if (frame_done) fd_cnt++;
        chk(frame_done == prev_last, "frame_done", TBITS'(frame_done), TBITS'(prev_last));
        prev_last = 0;
        if (expect_valid) begin
          chk(tvalid == 1'b1, "tvalid_latency", TBITS'(tvalid), 1);
          expect_valid = 0;
        end
        if (tvalid) begin
          if (exp_q.size() == 0) begin
            chk(1'b0, "spurious_beat", tdata, '0);
          end else begin
            e = exp_q[0];
            chk(tdata == e.d, "tdata", tdata, e.d);
            chk(tkeep == '1, "tkeep_on", TBITS'(tkeep), TBITS'(8'hff));
`ifdef QR_OUT_TLAST_EN
            chk(tlast == e.last, "tlast", TBITS'(tlast), TBITS'(e.last));
`else
            chk(tlast == 1'b0, "tlast_off", TBITS'(tlast), 0);
`endif
            if (tready) begin
              void'(exp_q.pop_front());
              prev_last = e.last;
            end
          end
        end else begin
          chk(tkeep == '0, "tkeep_off", TBITS'(tkeep), 0);
          chk(tlast == 1'b0, "tlast_idle", TBITS'(tlast), 0);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [TBITS-1:0] w;
    aresetn   = 1'b0;
    res_valid = 1'b0;
    res_data  = '0;
    #12;
    chk(tvalid == 1'b0, "rst_tvalid", TBITS'(tvalid), 0);
    chk(res_ready == 1'b1, "rst_ready", TBITS'(res_ready), 1);
    chk(frame_done == 1'b0, "rst_frame_done", TBITS'(frame_done), 0);
    chk(ovf_err == 1'b0, "rst_ovf", TBITS'(ovf_err), 0);
    chk(tlast == 1'b0, "rst_tlast", TBITS'(tlast), 0);
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    idle(1);

    // Basic frame, free-flowing output.
    tr_mode = 0;
    for (int i = 1; i <= NUM_COL; i++) send_word(TBITS'(i));
    wait_drained();
    chk(ovf_err == exp_ovf, "ovf_basic", TBITS'(ovf_err), TBITS'(exp_ovf));

    // Backpressure pattern 1,0,0,1.
    tr_mode = 1;
    for (int i = 1; i <= NUM_COL; i++) send_word(TBITS'(64'h100 + i));
    wait_drained();

    // Writes attempted during drain must be refused and flagged.
    tr_mode = 3;
    for (int i = 1; i <= NUM_COL; i++) send_word(TBITS'(64'h300 + i));
    if (exp_q.size() != 0) exp_ovf = 1;
    res_valid = 1'b1;
    res_data  = 64'hdead_beef_dead_beef;
    idle(5);
    res_valid = 1'b0;
    chk(ovf_err == exp_ovf, "ovf_set", TBITS'(ovf_err), TBITS'(exp_ovf));
    tr_mode = 0;
    wait_drained();
    chk(ovf_err == exp_ovf, "ovf_sticky", TBITS'(ovf_err), TBITS'(exp_ovf));

    // Reset in the middle of a fill discards the partial frame.
    for (int i = 1; i <= 5; i++) send_word(TBITS'(64'h500 + i));
    aresetn = 1'b0;
    #2;
    cur.delete();
    exp_ovf = 0;
    chk(tvalid == 1'b0, "midrst_tvalid", TBITS'(tvalid), 0);
    chk(ovf_err == 1'b0, "midrst_ovf", TBITS'(ovf_err), 0);
    chk(res_ready == 1'b1, "midrst_ready", TBITS'(res_ready), 1);
    idle(2);
    aresetn = 1'b1;
    idle(1);
    for (int i = 1; i <= NUM_COL; i++) send_word(TBITS'(i));
    wait_drained();

    // Two frames back to back: the second waits for the first to drain.
    for (int i = 0; i < NUM_COL; i++) send_word({8{8'h11}} ^ TBITS'(i));
    for (int i = 0; i < NUM_COL; i++) send_word({8{8'h22}} ^ TBITS'(i));
    wait_drained();
    chk(ovf_err == exp_ovf, "ovf_b2b", TBITS'(ovf_err), TBITS'(exp_ovf));

    // Random data, random gaps, random downstream ready.
    tr_mode = 2;
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < NUM_COL; i++) begin
        w = {$urandom, $urandom};
        send_word(w);
        idle($urandom_range(0, 2));
      end
    end
    wait_drained();
    tr_mode = 0;
    idle(3);
    chk(fd_cnt == exp_frames, "frame_count", TBITS'(fd_cnt), TBITS'(exp_frames));
    chk(ovf_err == exp_ovf, "ovf_final", TBITS'(ovf_err), TBITS'(exp_ovf));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/qr_out_packer.md
QR_OUT_PACKER -- requirements
Module: qr_out_packer

Interface
REQ-001 Parameter TBITS, default 64, stream data width in bits.
REQ-002 Parameter TBYTE, default 8, keep width, equal to TBITS/8.
REQ-003 Parameter NUM_COL, default 8, result words per matrix frame, power of two, minimum 2.
REQ-004 Port aclk, input, 1, sole clock; all state on rising edge.
REQ-005 Port aresetn, input, 1, asynchronous active-low reset.
REQ-006 Port res_valid, input, 1, CORDIC core result word valid.
REQ-007 Port res_ready, output, 1, packer accepts the result word this cycle.
REQ-008 Port res_data, input, TBITS, result column word from the CORDIC core.
REQ-009 Port M_AXIS_S2MM_TVALID, output, 1, output beat valid.
REQ-010 Port M_AXIS_S2MM_TREADY, input, 1, downstream accepts beat.
REQ-011 Port M_AXIS_S2MM_TDATA, output, TBITS, output beat data.
REQ-012 Port M_AXIS_S2MM_TKEEP, output, TBYTE, byte enables.
REQ-013 Port M_AXIS_S2MM_TLAST, output, 1, last beat of frame.
REQ-014 Port frame_done, output, 1, one-cycle pulse after the final beat of a frame is transferred.
REQ-015 Port ovf_err, output, 1, sticky flag: res_valid asserted while res_ready low.

Function
REQ-016 The block SHALL buffer NUM_COL TBITS-wide words in registers, indexed by wr_ptr and rd_ptr, each log2(NUM_COL) bits wide.
REQ-017 FSM states SHALL be FILL and DRAIN; the reset state is FILL.
REQ-018 In FILL, res_ready SHALL be 1 and M_AXIS_S2MM_TVALID SHALL be 0.
REQ-019 In FILL, on res_valid=1 the block SHALL write res_data to buf[wr_ptr] and increment wr_ptr.
REQ-020 When word NUM_COL-1 is written, wr_ptr SHALL wrap to 0 and the FSM SHALL enter DRAIN on the next edge.
REQ-021 Latency: M_AXIS_S2MM_TVALID SHALL rise in the cycle immediately after the last word is accepted.
REQ-022 In DRAIN, res_ready SHALL be 0, M_AXIS_S2MM_TVALID SHALL be 1, and TDATA SHALL be buf[rd_ptr].
REQ-023 In DRAIN, TVALID SHALL stay high and TDATA SHALL stay stable until TREADY=1; no beat is dropped or repeated.
REQ-024 On TVALID&TREADY, rd_ptr SHALL increment.
REQ-025 On the beat with rd_ptr=NUM_COL-1, rd_ptr SHALL wrap to 0, the FSM SHALL return to FILL, and frame_done SHALL pulse in the next cycle.
REQ-026 M_AXIS_S2MM_TKEEP SHALL be all ones whenever TVALID=1 and 0 otherwise.
REQ-027 res_valid=1 while res_ready=0 SHALL leave the buffer unchanged and SHALL set ovf_err, which holds until reset.
REQ-028 No simultaneous fill and drain: a new frame SHALL start only in the FILL cycle after the last beat.

Reset
REQ-029 Asserting aresetn low SHALL asynchronously force: FSM to FILL, wr_ptr=0, rd_ptr=0, TVALID=0, TLAST=0, frame_done=0, ovf_err=0.
REQ-030 Buffer contents SHALL NOT be reset.
REQ-031 A reset asserted mid-fill or mid-drain SHALL discard the partial frame; the next frame starts at word 0.

Configuration
REQ-032 Macro QR_OUT_TLAST_EN defined: TLAST SHALL equal TVALID & (rd_ptr==NUM_COL-1).
REQ-033 Macro QR_OUT_TLAST_EN undefined: TLAST SHALL be constant 0 and no TLAST logic is synthesized; frame_done is unaffected.

Structure
REQ-034 The shared package qr_pkg SHALL hold TBITS, TBYTE, NUM_COL defaults and the FSM state encoding.
REQ-035 There is no sub-module; the buffer, pointers and FSM are in one module.

Verification
REQ-036 Reset, then 8 words 0x0000_0000_0000_0001..0x...0008 with TREADY=1: 8 consecutive beats in order; TLAST only on 0x...0008; frame_done pulses once.
REQ-037 Backpressure: TREADY toggled 1,0,0,1 per cycle: each word appears exactly once; TDATA is stable while TREADY=0.
REQ-038 res_valid held high during DRAIN: ovf_err=1 and the drained frame is unchanged.
REQ-039 aresetn pulsed low after 5 of 8 words: TVALID=0; the next 8 words output 0x...0001 first.
REQ-040 Two back-to-back frames (0x11.. then 0x22..): res_ready stays 0 until frame 1's last beat, then frame 2 is output intact.
REQ-041 Build without QR_OUT_TLAST_EN, rerun REQ-036: TLAST is always 0; all other responses are identical.
